// File: rtl/pio_loader.sv
// pio_loader: configuration sequencer placed in front of a pio block.
//
// On an accepted start pulse it copies a program from an external
// synchronous ROM into pio instruction memory, then writes wrap/exec
// control, clock divider and pin groups. It can optionally push one TX word
// and issue up to two immediate instructions. Last, it enables the selected
// state machines. Every command is asserted for exactly one cycle and is
// followed by one NONE cycle.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   start      single-cycle load request (ignored while busy)
//   plen       program length in words, clamped to MAX_PLEN
//   sm         target state machine (driven on mindex while busy)
//   exec_ctrl  PEND payload
//   div        DIV payload (zero-extended)
//   pin_grps   GRPS payload
//   push_en    issue the PUSH step
//   push_word  PUSH payload
//   imm_cnt    number of IMM steps (3 behaves as 2)
//   imm0/imm1  IMM payloads (zero-extended), imm0 issued first
//   en_mask    EN payload (zero-extended)
//   tx_full    per-machine TX FIFO full flags from pio
//   prog_addr  ROM address; ROM data returns one cycle later
//   prog_data  ROM data
//   action     pio command code
//   index      instruction index for INSTR commands
//   mindex     machine index
//   din        command payload
//   busy       sequence in progress
//   done       one-cycle completion pulse
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start, all outputs at rest
// FETCH      | first ROM address on the bus, no command
// INSTR      | writing one program word into instruction memory
// GAP        | NONE cycle after a command; next ROM address is on the bus
// PEND       | writing wrap/exec control
// DIV        | writing the clock divider
// GRPS       | writing pin groups
// PUSH_WAIT  | holding the TX push while the target FIFO is full
// PUSH       | pushing one TX word
// IMM        | issuing one immediate instruction
// EN         | enabling state machines
// DONE       | done pulse, returning to IDLE

module pio_loader #(
  parameter int MAX_PLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  plen,
  input  logic [1:0]  sm,
  input  logic [31:0] exec_ctrl,
  input  logic [23:0] div,
  input  logic [31:0] pin_grps,
  input  logic        push_en,
  input  logic [31:0] push_word,
  input  logic [1:0]  imm_cnt,
  input  logic [15:0] imm0,
  input  logic [15:0] imm1,
  input  logic [3:0]  en_mask,
  input  logic [3:0]  tx_full,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] ACT_NONE  = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PEND  = 4'd2;
  localparam logic [3:0] ACT_PUSH  = 4'd4;
  localparam logic [3:0] ACT_GRPS  = 4'd5;
  localparam logic [3:0] ACT_EN    = 4'd6;
  localparam logic [3:0] ACT_DIV   = 4'd7;
  localparam logic [3:0] ACT_IMM   = 4'd9;

  localparam logic [5:0] PLEN_CAP = 6'(MAX_PLEN);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_INSTR,
    S_GAP,
    S_PEND,
    S_DIV,
    S_GRPS,
    S_PUSH_WAIT,
    S_PUSH,
    S_IMM,
    S_EN,
    S_DONE
  } state_t;

  state_t      state_q;
  state_t      ret_q;        // step to take when the current NONE cycle ends
  logic [5:0]  words_left;   // program words still to write, counts down
  logic [4:0]  word_idx;     // index of the next program word
  logic [1:0]  imm_left;     // immediates still to issue, counts down
  logic        imm_sel;      // 0: next immediate is imm0, 1: imm1

  logic [1:0]  sm_q;
  logic [31:0] exec_q;
  logic [23:0] div_q;
  logic [31:0] grps_q;
  logic        push_en_q;
  logic [31:0] push_word_q;
  logic [15:0] imm0_q;
  logic [15:0] imm1_q;
  logic [3:0]  en_q;

  state_t      tgt;          // step actually entered after this NONE cycle
  state_t      cmd_ret;      // step following tgt
  state_t      imm_next;
  logic [3:0]  cmd_action;
  logic [4:0]  cmd_index;
  logic [31:0] cmd_din;

  // Resolve the pending step: an exhausted program skips straight to PEND,
  // and a full TX FIFO turns PUSH into PUSH_WAIT.
  always_comb begin
    imm_next = (imm_left != 2'd0) ? S_IMM : S_EN;

    tgt = ret_q;
    if (ret_q == S_INSTR && words_left == 6'd0) begin
      tgt = S_PEND;
    end
    if (ret_q == S_PUSH && tx_full[sm_q]) begin
      tgt = S_PUSH_WAIT;
    end

    cmd_action = ACT_NONE;
    cmd_index  = 5'd0;
    cmd_din    = 32'd0;
    cmd_ret    = S_IDLE;
    case (tgt)
      S_INSTR: begin
        cmd_action = ACT_INSTR;
        cmd_index  = word_idx;
        cmd_din    = {16'h0000, prog_data};
        cmd_ret    = S_INSTR;
      end
      S_PEND: begin
        cmd_action = ACT_PEND;
        cmd_din    = exec_q;
        cmd_ret    = S_DIV;
      end
      S_DIV: begin
        cmd_action = ACT_DIV;
        cmd_din    = {8'h00, div_q};
        cmd_ret    = S_GRPS;
      end
      S_GRPS: begin
        cmd_action = ACT_GRPS;
        cmd_din    = grps_q;
        cmd_ret    = push_en_q ? S_PUSH : imm_next;
      end
      S_PUSH_WAIT: begin
        cmd_ret = S_PUSH;
      end
      S_PUSH: begin
        cmd_action = ACT_PUSH;
        cmd_din    = push_word_q;
        cmd_ret    = imm_next;
      end
      S_IMM: begin
        cmd_action = ACT_IMM;
        cmd_din    = {16'h0000, imm_sel ? imm1_q : imm0_q};
        cmd_ret    = (imm_left > 2'd1) ? S_IMM : S_EN;
      end
      S_EN: begin
        cmd_action = ACT_EN;
        cmd_din    = {28'h0000000, en_q};
        cmd_ret    = S_DONE;
      end
      default: begin
        cmd_ret = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      words_left  <= 6'd0;
      word_idx    <= 5'd0;
      imm_left    <= 2'd0;
      imm_sel     <= 1'b0;
      sm_q        <= 2'd0;
      exec_q      <= 32'd0;
      div_q       <= 24'd0;
      grps_q      <= 32'd0;
      push_en_q   <= 1'b0;
      push_word_q <= 32'd0;
      imm0_q      <= 16'd0;
      imm1_q      <= 16'd0;
      en_q        <= 4'd0;
      prog_addr   <= 5'd0;
      action      <= ACT_NONE;
      index       <= 5'd0;
      mindex      <= 2'd0;
      din         <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Commands last one cycle: outputs fall back to NONE unless set below.
      action <= ACT_NONE;
      index  <= 5'd0;
      din    <= 32'd0;
      done   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            sm_q        <= sm;
            exec_q      <= exec_ctrl;
            div_q       <= div;
            grps_q      <= pin_grps;
            push_en_q   <= push_en;
            push_word_q <= push_word;
            imm0_q      <= imm0;
            imm1_q      <= imm1;
            en_q        <= en_mask;
            words_left  <= (plen > PLEN_CAP) ? PLEN_CAP : plen;
            word_idx    <= 5'd0;
            imm_left    <= (imm_cnt == 2'd3) ? 2'd2 : imm_cnt;
            imm_sel     <= 1'b0;
            ret_q       <= S_INSTR;
            prog_addr   <= 5'd0;
            mindex      <= sm;
            busy        <= 1'b1;
            state_q     <= S_FETCH;
          end
        end

        S_FETCH, S_GAP, S_PUSH_WAIT: begin
          state_q <= tgt;
          ret_q   <= cmd_ret;
          action  <= cmd_action;
          index   <= cmd_index;
          din     <= cmd_din;
          if (tgt == S_INSTR) begin
            words_left <= words_left - 6'd1;
            word_idx   <= word_idx + 5'd1;
            // The ROM answers one cycle late, so the next address goes out
            // now and its data is ready when the following GAP ends.
            prog_addr  <= (words_left == 6'd1) ? 5'd0 : word_idx + 5'd1;
          end
          if (tgt == S_IMM) begin
            imm_left <= imm_left - 2'd1;
            imm_sel  <= 1'b1;
          end
        end

        S_INSTR, S_PEND, S_DIV, S_GRPS, S_PUSH, S_IMM: begin
          state_q <= S_GAP;
        end

        S_EN: begin
          done    <= 1'b1;
          state_q <= S_DONE;
        end

        S_DONE: begin
          busy    <= 1'b0;
          mindex  <= 2'd0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pio_loader.md
# pio_loader

Configuration sequencer that sits directly upstream of `pio` and drives its `action`/`index`/`mindex`/`din` command port. On a start pulse it streams a program from an external synchronous ROM into instruction memory, writes wrap/exec control, clock divider and pin groups, optionally pushes one TX word and issues up to two immediate instructions, then enables the selected state machines. It replaces hand-sequenced bring-up, such as a stepper half-step table load, with a fixed, cycle-exact hardware sequence.

## Interface
- `MAX_PLEN`, default 32: instruction memory depth; `plen` is clamped to this value.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset; 0 resets the block on the next `clk` edge.
- `start` in 1: single-cycle pulse that begins a load; ignored while `busy`=1.
- `plen` in 6: number of program words to load (0..63, clamped to `MAX_PLEN`).
- `sm` in 2: target state machine, driven on `mindex`.
- `exec_ctrl` in 32: PEND payload (wrap/exec control).
- `div` in 24: DIV payload, zero-extended to 32 bits.
- `pin_grps` in 32: GRPS payload.
- `push_en` in 1: issue the PUSH step.
- `push_word` in 32: PUSH payload.
- `imm_cnt` in 2: number of IMM steps, 0..2; the value 3 is treated as 2.
- `imm0`, `imm1` in 16 each: IMM payloads, zero-extended to 32 bits.
- `en_mask` in 4: EN payload, zero-extended to 32 bits.
- `tx_full` in 4: from `pio`; `tx_full[sm]` stalls the PUSH step.
- `prog_addr` out 5: ROM address.
- `prog_data` in 16: ROM data, valid one cycle after `prog_addr`.
- `action` out 4: codes are NONE=0, INSTR=1, PEND=2, PUSH=4, GRPS=5, EN=6, DIV=7, IMM=9.
- `index` out 5: instruction index.
- `mindex` out 2: machine index.
- `din` out 32: command payload.
- `busy` out 1: high from the cycle after `start` is accepted through the cycle with `done`=1.
- `done` out 1: one-cycle pulse when the sequence completes.

## Operation
- All inputs except `tx_full`, `prog_data` and `reset` are latched on the `start` edge. They may change freely afterwards.
- States:
  - IDLE
  - FETCH: `prog_addr`=i
  - INSTR: `action`=1, `index`=i, `din`={16'h0,`prog_data`}
  - GAP
  - PEND
  - DIV
  - GRPS
  - PUSH_WAIT
  - PUSH
  - IMM
  - EN
  - DONE
- Every non-NONE command is asserted for exactly one cycle and is followed by exactly one NONE cycle (GAP).
- During GAP after INSTR i, `prog_addr` presents i+1. This makes the next cycle INSTR i+1 with no separate FETCH, so the load takes 2 cycles per word.
- Sequence order: INSTR 0..plen-1, then PEND, DIV, GRPS, then PUSH if `push_en`, then IMM×imm_cnt (imm0 first), then EN, then DONE.
- DONE: `action`=NONE and `done`=1 for one cycle, then return to IDLE.
- PUSH_WAIT is entered in place of PUSH and stays while `tx_full[sm]`=1, with `action`=NONE. It proceeds to PUSH on the first cycle where `tx_full[sm]`=0. There is no timeout.
- While `action`=NONE: `index`=0 and `din`=0.
- `mindex`=latched `sm` while `busy`=1, and 0 otherwise.
- `plen`=0: skip FETCH/INSTR; go from FETCH-slot GAP straight to PEND.
- `plen`>`MAX_PLEN`: load `MAX_PLEN` words, at indices 0..MAX_PLEN-1.
- `start` arriving while `busy`=1 is dropped, with no queueing.
- `start` on the same edge as `done`: ignored.
- Reset (`reset`=0) mid-sequence: the next edge forces IDLE. All outputs go to 0 and `action`=NONE. No partial command is ever extended.

## Timing
- Cycle 0 is the edge that samples `start`=1. Cycle n is the n-th cycle after it.
- With `plen`=P≥1:
  - Cycle 1: FETCH, `prog_addr`=0.
  - INSTR k occurs at cycle 2k+2.
  - GAP occurs at cycle 2k+3.
- PEND occurs at cycle 2P+2; this also holds for P=0, giving cycle 2.
- After PEND, each further step adds 2 cycles, plus any PUSH_WAIT stall cycles.
- `done` occurs one cycle after EN.
- Reset values: `action`=0, `index`=0, `mindex`=0, `din`=0, `prog_addr`=0, `busy`=0, `done`=0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- P=4, push_en=1, imm_cnt=2, tx_full=0, no stalls:
  - INSTR 0..3 appear at cycles 2,4,6,8.
  - PEND=32'h3000 at cycle 10, DIV=32'h0100 at 12, GRPS=32'h00400000 at 14.
  - PUSH=32'h8C46_2319 at 16.
  - IMM=16'h8080 at 18, IMM=16'hA0C7 at 20.
  - EN=1 at 22, `done` at 23.
- Same as above with `tx_full[0]`=1 for cycles 15..19: PUSH moves to cycle 20, and EN and `done` shift by +4.
- P=0, push_en=0, imm_cnt=0: PEND at 2, DIV at 4, GRPS at 6, EN at 8, `done` at 9.
- P=40: exactly 32 INSTR commands, indices 0..31; `prog_addr` never exceeds 31.
- `reset`=0 at cycle 7 of a P=4 run: `action`=0 and `busy`=0 from cycle 8. A new `start` after reset release replays the sequence from INSTR 0.
- `start` pulsed at cycle 5 during a run: the sequence is unchanged and only one `done` pulse is produced.
